muldiv32: RTL and testbench

- Iterative multiply/divide unit with architectural HI/LO registers, directly downstream of the register-file/decode stage.
- Consumes read_data_1 (rs) and read_data_2 (rt) and executes mult, multu, div, divu, mthi and mtlo.
- Exposes HI/LO to the writeback mux for mfhi/mflo.
- Raises busy so the controller can stall fetch while an operation runs.

---
 rtl/muldiv32_if.sv | 28 ++
 rtl/muldiv32.sv | 159 +++++++++++++++
 tb/tb_muldiv32.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv32_if.sv
// muldiv32_if: request/operand/result bundle between decode and the muldiv32 unit.
interface muldiv32_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] read_data_1;
    logic [XLEN-1:0] read_data_2;
    logic            mthi;
    logic            mtlo;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    // Issuing side (decode / testbench)
    modport master (
        output start, op, read_data_1, read_data_2, mthi, mtlo,
        input  busy, done, div_by_zero, hi, lo
    );

    // Execution unit side
    modport slave (
        input  start, op, read_data_1, read_data_2, mthi, mtlo,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv32.sv
// muldiv32: iterative 32-bit mult/multu/div/divu unit with HI/LO registers.
// Operands are latched as magnitudes at start; RUN does one shift-add or
// restoring-divide step per cycle; FIX applies signs and writes HI/LO.
// Optional: define MULDIV_EARLY_ZERO_EN to finish zero-operand ops in 2 edges.
module muldiv32 #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ITER = 32
) (
    input  logic       clock,
    input  logic       reset,
    muldiv32_if.slave  bus
);
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic            is_div;
    logic            res_neg;
    logic            rem_neg;
    logic            dz;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;

    logic            a_neg_c;
    logic            b_neg_c;
    logic [XLEN-1:0] a_abs_c;
    logic [XLEN-1:0] b_abs_c;
    logic            early_c;
    logic [XLEN:0]   mul_sum_c;
    logic [XLEN:0]   div_shift_c;
    logic [XLEN:0]   div_diff_c;
    logic [XLEN-1:0] res_hi_c;
    logic [XLEN-1:0] res_lo_c;

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

    // Operand magnitudes; op[0] = 0 selects the signed variants
    assign a_neg_c = ~bus.op[0] & bus.read_data_1[XLEN-1];
    assign b_neg_c = ~bus.op[0] & bus.read_data_2[XLEN-1];
    assign a_abs_c = a_neg_c ? XLEN'(XLEN'(0) - bus.read_data_1) : bus.read_data_1;
    assign b_abs_c = b_neg_c ? XLEN'(XLEN'(0) - bus.read_data_2) : bus.read_data_2;

`ifdef MULDIV_EARLY_ZERO_EN
    // Zero product or zero dividend with a valid divisor: result is known to be 0
    assign early_c = bus.op[1]
                   ? ((bus.read_data_1 == '0) && (bus.read_data_2 != '0))
                   : ((bus.read_data_1 == '0) || (bus.read_data_2 == '0));
`else
    assign early_c = 1'b0;
`endif

    // One shift-add multiply step (LSB of acc_lo is the current multiplier bit)
    assign mul_sum_c   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : (XLEN+1)'(0));
    // One restoring divide step: shift in next dividend bit, trial-subtract divisor
    assign div_shift_c = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff_c  = div_shift_c - {1'b0, opnd};

    // Sign fix-up of the finished magnitude result
    always_comb begin
        res_hi_c = acc_hi;
        res_lo_c = acc_lo;
        if (is_div) begin
            if (res_neg) res_lo_c = XLEN'(XLEN'(0) - acc_lo);
            if (rem_neg) res_hi_c = XLEN'(XLEN'(0) - acc_hi);
        end else if (res_neg) begin
            {res_hi_c, res_lo_c} = (2*XLEN)'((2*XLEN)'(0) - {acc_hi, acc_lo});
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.start) state_next = early_c ? FIX : RUN;
            RUN:  if (count == CW'(ITER - 1)) state_next = FIX;
            FIX:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz      <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (bus.start) begin
                        acc_hi  <= '0;
                        acc_lo  <= early_c ? XLEN'(0) : a_abs_c;
                        opnd    <= b_abs_c;
                        is_div  <= bus.op[1];
                        res_neg <= a_neg_c ^ b_neg_c;
                        rem_neg <= a_neg_c;
                        dz      <= bus.op[1] && (bus.read_data_2 == '0);
                    end else begin
                        if (bus.mthi) hi_q <= bus.read_data_1;
                        if (bus.mtlo) lo_q <= bus.read_data_1;
                    end
                end
                RUN: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        acc_hi <= div_diff_c[XLEN] ? div_shift_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], ~div_diff_c[XLEN]};
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum_c, acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    count  <= '0;
                    done_q <= 1'b1;
                    if (dz) begin
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= res_hi_c;
                        lo_q <= res_lo_c;
                    end
                end
                default: count <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv32.sv
// tb_muldiv32: directed vector table, hand-written corner sequences and random
// operations checked against an arithmetic reference model of HI/LO.
module tb_muldiv32;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    muldiv32_if #(.XLEN(32)) bus ();
    muldiv32 #(.XLEN(32), .ITER(32)) dut (.clock(clock), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        string       name;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected cycles (negedges with busy) before the done cycle
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_ZERO_EN
        if (!op[1] && (a == 32'h0 || b == 32'h0)) return 1;
        if (op[1] && a == 32'h0 && b != 32'h0) return 1;
`endif
        return 33;
    endfunction

    // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] ch,
                                           input logic [31:0] cl);
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        logic [63:0] v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'd0: begin sp = sa * sb; v = sp; return {1'b0, v}; end
            2'd1: begin up = ua * ub; v = up; return {1'b0, v}; end
            2'd2: begin
                if (b == 32'h0) return {1'b1, ch, cl};
                sq = sa / sb; sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'h0) return {1'b1, ch, cl};
                uq = ua / ub; ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Issue one op at a negedge, wait for done, check latency/busy/pulse width
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mt, input string name,
                          output logic [31:0] got_hi, output logic [31:0] got_lo,
                          output logic got_dz);
        int lat = 0;
        int busy_cnt = 0;
        bus.op = op; bus.read_data_1 = a; bus.read_data_2 = b;
        bus.mthi = with_mt; bus.mtlo = with_mt; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.op = 2'($urandom);
        bus.read_data_1 = $urandom; bus.read_data_2 = $urandom;
        while (!bus.done && lat < 100) begin
            if (bus.busy) busy_cnt++;
            lat++;
            @(negedge clock);
            bus.read_data_1 = $urandom; bus.read_data_2 = $urandom;
        end
        got_hi = bus.hi; got_lo = bus.lo; got_dz = bus.div_by_zero;
        check({name, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat(op, a, b)));
        check({name, " busy in done cycle"}, {31'h0, bus.busy}, 32'h0);
        @(negedge clock);
        check({name, " done width"}, {31'h0, bus.done}, 32'h0);
    endtask

    task automatic move_to(input bit to_hi, input bit to_lo, input logic [31:0] v);
        bus.mthi = to_hi; bus.mtlo = to_lo; bus.read_data_1 = v;
        @(negedge clock);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        if (to_hi) m_hi = v;
        if (to_lo) m_lo = v;
        check("mt hi", bus.hi, m_hi);
        check("mt lo", bus.lo, m_lo);
        check("mt no done", {31'h0, bus.done}, 32'h0);
    endtask

    initial begin
        logic [31:0] gh, gl;
        logic        gd;
        logic [64:0] r;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          n;
        int          pulses;

        vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"};
        vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3x7"};
        vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"};
        vecs[3] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"};
        vecs[4] = '{2'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu 100/7"};
        vecs[5] = '{2'd0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, "mult 0x5"};
        vecs[6] = '{2'd3, 32'h00000000, 32'h00000009, 32'h00000000, 32'h00000000, "divu 0/9"};
        vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min^2"};
        vecs[8] = '{2'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu max/1"};
        vecs[9] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"};

        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        bus.read_data_1 = 32'h0; bus.read_data_2 = 32'h0;
        repeat (2) @(negedge clock);
        check("reset busy", {31'h0, bus.busy}, 32'h0);
        check("reset done", {31'h0, bus.done}, 32'h0);
        check("reset dbz", {31'h0, bus.div_by_zero}, 32'h0);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].name, gh, gl, gd);
            check({vecs[i].name, " hi"}, gh, vecs[i].exp_hi);
            check({vecs[i].name, " lo"}, gl, vecs[i].exp_lo);
            check({vecs[i].name, " dbz"}, {31'h0, gd}, 32'h0);
            m_hi = vecs[i].exp_hi; m_lo = vecs[i].exp_lo;
        end

        // mthi/mtlo then divide by zero leaves HI/LO untouched
        move_to(1'b1, 1'b0, 32'h12345678);
        move_to(1'b0, 1'b1, 32'h9ABCDEF0);
        run_op(2'd3, 32'h7, 32'h0, 1'b0, "divu by 0", gh, gl, gd);
        check("divu by 0 dbz", {31'h0, gd}, 32'h1);
        check("divu by 0 hi", gh, 32'h12345678);
        check("divu by 0 lo", gl, 32'h9ABCDEF0);

        // Reset at cycle 10 of divu 100/7 discards the operation
        bus.op = 2'd3; bus.read_data_1 = 32'd100; bus.read_data_2 = 32'd7; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset busy", {31'h0, bus.busy}, 32'h0);
        check("midreset done", {31'h0, bus.done}, 32'h0);
        check("midreset hi", bus.hi, 32'h0);
        check("midreset lo", bus.lo, 32'h0);
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done || bus.busy) pulses++;
        end
        check("midreset no activity", 32'(pulses), 32'h0);
        m_hi = 32'h0; m_lo = 32'h0;

        // Second start and mthi during a running mult 2x3 are ignored
        bus.op = 2'd0; bus.read_data_1 = 32'd2; bus.read_data_2 = 32'd3; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        n = 1;
        repeat (4) begin @(negedge clock); n++; end
        bus.start = 1'b1; bus.op = 2'd3; bus.mthi = 1'b1; bus.read_data_1 = 32'hDEADBEEF;
        @(negedge clock);
        n++;
        bus.start = 1'b0; bus.mthi = 1'b0;
        while (!bus.done && n < 100) begin @(negedge clock); n++; end
        check("inject done edge", 32'(n), 32'd34);
        check("inject hi", bus.hi, 32'h0);
        check("inject lo", bus.lo, 32'd6);
        @(negedge clock);
        check("inject no restart", {31'h0, bus.busy}, 32'h0);
        m_hi = 32'h0; m_lo = 32'd6;

        // Both moves at once, then start together with mthi/mtlo: start wins
        move_to(1'b1, 1'b1, 32'hA5A55A5A);
        run_op(2'd1, 32'd9, 32'd11, 1'b1, "start+mt", gh, gl, gd);
        check("start+mt hi", gh, 32'h0);
        check("start+mt lo", gl, 32'd99);
        m_hi = 32'h0; m_lo = 32'd99;

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h0;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            r = ref_op(rop, ra, rb, m_hi, m_lo);
            run_op(rop, ra, rb, 1'b0, "rand", gh, gl, gd);
            check("rand hi", gh, r[63:32]);
            check("rand lo", gl, r[31:0]);
            check("rand dbz", {31'h0, gd}, {31'h0, r[64]});
            m_hi = r[63:32]; m_lo = r[31:0];
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
